// File: rtl/buzzer_pkg.sv
// Shared constants, step-word layout and FSM states for the buzzer scheduler.
// Imported by buzzer_pattern_rom and buzzer_sched.
package buzzer_pkg;

  localparam int NUM_REQ = 3;
  localparam int IDX_W   = 2;
  localparam int NOTE_W  = 5;
  localparam int DUR_W   = 6;
  localparam int STEP_W  = 3;

  // step word = {last, note, dur}
  localparam int WORD_W   = 1 + NOTE_W + DUR_W;
  localparam int DUR_LSB  = 0;
  localparam int NOTE_LSB = DUR_W;
  localparam int LAST_BIT = DUR_W + NOTE_W;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd31;

  localparam logic [IDX_W-1:0] REQ_PLACE   = 2'd0;
  localparam logic [IDX_W-1:0] REQ_ILLEGAL = 2'd1;
  localparam logic [IDX_W-1:0] REQ_WIN     = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] mk_step(
    input logic              last,
    input logic [NOTE_W-1:0] note,
    input logic [DUR_W-1:0]  dur
  );
    return {last, note, dur};
  endfunction

endpackage

// File: rtl/buzzer_pattern_rom.sv
// Per-requester note pattern ROM: maps {req_idx, step_idx} to a step word.
// Ports: req_idx (pattern select), step_idx (step in pattern), word (step word).
module buzzer_pattern_rom
  import buzzer_pkg::*;
(
  input  logic [IDX_W-1:0]  req_idx,
  input  logic [STEP_W-1:0] step_idx,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    // unused slots end the pattern on a silent one-tick step
    word = mk_step(1'b1, NOTE_REST, 6'd1);
    case ({req_idx, step_idx})
      {REQ_PLACE, 3'd0}:   word = mk_step(1'b1, 5'd12, 6'd10);

      {REQ_ILLEGAL, 3'd0}: word = mk_step(1'b0, 5'd0, 6'd20);
      {REQ_ILLEGAL, 3'd1}: word = mk_step(1'b0, NOTE_REST, 6'd10);
      {REQ_ILLEGAL, 3'd2}: word = mk_step(1'b1, 5'd0, 6'd20);

      {REQ_WIN, 3'd0}:     word = mk_step(1'b0, 5'd21, 6'd25);
      {REQ_WIN, 3'd1}:     word = mk_step(1'b0, 5'd16, 6'd25);
      {REQ_WIN, 3'd2}:     word = mk_step(1'b0, 5'd14, 6'd25);
      {REQ_WIN, 3'd3}:     word = mk_step(1'b0, 5'd12, 6'd25);
      {REQ_WIN, 3'd4}:     word = mk_step(1'b0, 5'd9, 6'd25);
      {REQ_WIN, 3'd5}:     word = mk_step(1'b0, 5'd12, 6'd25);
      {REQ_WIN, 3'd6}:     word = mk_step(1'b0, 5'd14, 6'd25);
      {REQ_WIN, 3'd7}:     word = mk_step(1'b1, 5'd16, 6'd25);
      default:             word = mk_step(1'b1, NOTE_REST, 6'd1);
    endcase
  end

endmodule

// File: rtl/buzzer_sched.sv
// Buzzer scheduler: latches requests, grants by fixed priority with preemption,
// steps the owner's ROM pattern on tick. Ports: clk, rst, en, tick, req in;
// tone_en, tone_id, grant, busy, done out (all registered).
module buzzer_sched
  import buzzer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               tick,
  input  logic [NUM_REQ-1:0] req,
  output logic               tone_en,
  output logic [NOTE_W-1:0]  tone_id,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               done
);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  pending_q, pending_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic                tone_en_q, tone_en_d;
  logic [NOTE_W-1:0]   tone_id_q, tone_id_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [WORD_W-1:0]   rom_word;
  logic                rom_last;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;

  logic                hi_vld;
  logic [IDX_W-1:0]    hi_idx;
  logic                preempt;
  logic                grab;

  buzzer_pattern_rom u_rom (
    .req_idx  (owner_q),
    .step_idx (step_q),
    .word     (rom_word)
  );

  assign rom_last = rom_word[LAST_BIT];
  assign rom_note = rom_word[NOTE_LSB +: NOTE_W];
  assign rom_dur  = rom_word[DUR_LSB +: DUR_W];

  // highest set pending bit wins
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pending_q[i]) begin
        hi_vld = 1'b1;
        hi_idx = IDX_W'(i);
      end
    end
  end

  assign preempt = hi_vld && (hi_idx > owner_q) && (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req;
    owner_d   = owner_q;
    grant_d   = grant_q;
    step_d    = step_q;
    dur_cnt_d = dur_cnt_q;
    tone_en_d = tone_en_q;
    tone_id_d = tone_id_q;
    done_d    = 1'b0;
    grab      = 1'b0;

    if (!en) begin
      state_d   = IDLE;
      pending_d = '0;
      grant_d   = '0;
      tone_en_d = 1'b0;
      step_d    = '0;
      dur_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hi_vld) grab = 1'b1;
        end
        LOAD: begin
          if (preempt) begin
            grab = 1'b1;
          end else begin
            tone_id_d = rom_note;
            tone_en_d = (rom_note != NOTE_REST);
            dur_cnt_d = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
            state_d   = PLAY;
          end
        end
        PLAY: begin
          if (preempt) begin
            // preemption beats a same-cycle completion: no done
            grab = 1'b1;
          end else if (tick) begin
            if (dur_cnt_q <= DUR_W'(1)) begin
              if (rom_last) begin
                state_d   = IDLE;
                done_d    = 1'b1;
                tone_en_d = 1'b0;
                grant_d   = '0;
                step_d    = '0;
              end else begin
                step_d  = step_q + STEP_W'(1);
                state_d = LOAD;
              end
            end else begin
              dur_cnt_d = dur_cnt_q - DUR_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (grab) begin
        owner_d           = hi_idx;
        grant_d           = NUM_REQ'(1) << hi_idx;
        step_d            = '0;
        state_d           = LOAD;
        pending_d[hi_idx] = 1'b0;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      step_q    <= '0;
      dur_cnt_q <= '0;
      tone_en_q <= 1'b0;
      tone_id_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      step_q    <= step_d;
      dur_cnt_q <= dur_cnt_d;
      tone_en_q <= tone_en_d;
      tone_id_q <= tone_id_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tone_en = tone_en_q;
  assign tone_id = tone_id_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_buzzer_sched.sv
// Self-checking bench for buzzer_sched: directed scenarios plus random
// stimulus, compared every cycle against a behavioural scheduler model.
module tb_buzzer_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] req = 3'b000;
  logic       tone_en;
  logic [4:0] tone_id;
  logic [2:0] grant;
  logic       busy;
  logic       done;

  buzzer_sched dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .tick    (tick),
    .req     (req),
    .tone_en (tone_en),
    .tone_id (tone_id),
    .grant   (grant),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int p_note[3][8];
  int p_dur[3][8];
  int p_len[3];

  int m_pend[3];
  int m_owner = -1;
  int m_step = 0;
  int m_left = 0;
  bit m_load = 0;
  bit m_ten = 0;
  int m_tid = 0;
  bit m_done = 0;

  int tick_cnt = 0;
  bit rand_tick = 0;

  wire [10:0] obs = {busy, done, grant, tone_en, tone_id};

  function automatic logic [10:0] m_vec();
    logic [2:0] g;
    logic [4:0] t;
    g = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    t = 5'(m_tid);
    return {(m_owner >= 0), m_done, g, m_ten, t};
  endfunction

  // Advances the model by the clock edge that just happened, using the
  // inputs that were held across it.
  task automatic model_step();
    int top;
    int np[3];
    if (rst) begin
      for (int i = 0; i < 3; i++) m_pend[i] = 0;
      m_owner = -1; m_step = 0; m_left = 0;
      m_load = 0; m_ten = 0; m_tid = 0; m_done = 0;
    end else if (!en) begin
      for (int i = 0; i < 3; i++) m_pend[i] = 0;
      m_owner = -1; m_load = 0; m_ten = 0; m_done = 0;
    end else begin
      top = -1;
      for (int i = 0; i < 3; i++) begin
        if (m_pend[i] != 0) top = i;
        np[i] = (m_pend[i] != 0 || req[i]) ? 1 : 0;
      end
      m_done = 0;
      if (top >= 0 && (m_owner < 0 || top > m_owner)) begin
        m_owner = top; m_step = 0; m_load = 1; np[top] = 0;
      end else if (m_owner >= 0 && m_load) begin
        m_tid = p_note[m_owner][m_step];
        m_ten = (m_tid != 31);
        m_left = (p_dur[m_owner][m_step] > 0) ? p_dur[m_owner][m_step] : 1;
        m_load = 0;
      end else if (m_owner >= 0 && tick) begin
        if (m_left <= 1) begin
          if (m_step == p_len[m_owner] - 1) begin
            m_owner = -1; m_done = 1; m_ten = 0;
          end else begin
            m_step++; m_load = 1;
          end
        end else begin
          m_left--;
        end
      end
      for (int i = 0; i < 3; i++) m_pend[i] = np[i];
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
  endtask

  task automatic drive(input logic [2:0] r);
    req = r;
    if (rand_tick) begin
      tick = ($urandom_range(0, 3) == 0);
    end else begin
      tick_cnt++;
      tick = ((tick_cnt % 4) == 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (obs !== 11'd0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=000", i, obs);
      end
      drive(3'b000);
    end
    rst = 1'b0; en = 1'b1;
  endtask

  task automatic test_place();
    int nd = 0;
    for (int i = 0; i < 70; i++) begin
      cyc();
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL place cyc=%0d got=%h exp=%h", i, obs, m_vec());
      end
      if (i == 3) begin
        checks++;
        if ({tone_en, tone_id, grant} !== {1'b1, 5'd12, 3'b001}) begin
          errors++;
          $display("FAIL place_start got=%b/%0d/%b exp=1/12/001",
                   tone_en, tone_id, grant);
        end
      end
      if (done === 1'b1) nd++;
      drive(i == 0 ? 3'b001 : 3'b000);
    end
    checks++;
    if (nd != 1 || grant !== 3'b000) begin
      errors++;
      $display("FAIL place_done got=%0d/%b exp=1/000", nd, grant);
    end
  endtask

  task automatic test_illegal();
    int nd = 0;
    int nrest = 0;
    for (int i = 0; i < 240; i++) begin
      cyc();
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL illegal cyc=%0d got=%h exp=%h", i, obs, m_vec());
      end
      if (done === 1'b1) nd++;
      if (busy === 1'b1 && tone_en === 1'b0) nrest++;
      drive(i == 0 ? 3'b010 : 3'b000);
    end
    checks++;
    if (nd != 1 || nrest < 38 || nrest > 43) begin
      errors++;
      $display("FAIL illegal_shape done=%0d rest=%0d exp=1/38..43", nd, nrest);
    end
  endtask

  task automatic test_both();
    int nd = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL both cyc=%0d got=%h exp=%h", i, obs, m_vec());
      end
      if (i == 3) begin
        checks++;
        if ({grant, tone_id} !== {3'b100, 5'd21}) begin
          errors++;
          $display("FAIL both_first got=%b/%0d exp=100/21", grant, tone_id);
        end
      end
      if (done === 1'b1) nd++;
      drive(i == 0 ? 3'b101 : 3'b000);
    end
    checks++;
    if (nd != 2) begin
      errors++;
      $display("FAIL both_done got=%0d exp=2", nd);
    end
  endtask

  task automatic test_preempt();
    int nd = 0;
    for (int i = 0; i < 950; i++) begin
      cyc();
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL preempt cyc=%0d got=%h exp=%h", i, obs, m_vec());
      end
      if (i == 62) begin
        checks++;
        if (grant !== 3'b100) begin
          errors++;
          $display("FAIL preempt_grant got=%b exp=100", grant);
        end
      end
      if (i == 63) begin
        checks++;
        if ({tone_en, tone_id} !== {1'b1, 5'd21}) begin
          errors++;
          $display("FAIL preempt_tone got=%b/%0d exp=1/21", tone_en, tone_id);
        end
      end
      if (done === 1'b1) nd++;
      drive(i == 0 ? 3'b010 : (i == 60 ? 3'b100 : 3'b000));
    end
    checks++;
    if (nd != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL preempt_end done=%0d busy=%b exp=1/0", nd, busy);
    end
  endtask

  task automatic test_en_drop();
    int nb = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL endrop cyc=%0d got=%h exp=%h", i, obs, m_vec());
      end
      if (i == 121) begin
        checks++;
        if ({busy, tone_en, grant} !== 5'b0) begin
          errors++;
          $display("FAIL endrop_off got=%b/%b/%b exp=0/0/000",
                   busy, tone_en, grant);
        end
      end
      if (i > 121 && busy === 1'b1) nb++;
      en = !(i >= 120 && i < 125);
      drive(i == 0 ? 3'b100 : (i == 100 ? 3'b001 : 3'b000));
    end
    en = 1'b1;
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL endrop_flush busy_cycles=%0d exp=0", nb);
    end
  endtask

  task automatic test_rst_mid();
    int nb = 0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL rstmid cyc=%0d got=%h exp=%h", i, obs, m_vec());
      end
      if (i == 21) begin
        checks++;
        if (obs !== 11'd0) begin
          errors++;
          $display("FAIL rstmid_zero got=%h exp=000", obs);
        end
      end
      if (i > 21 && i <= 61 && busy === 1'b1) nb++;
      if (i == 63) begin
        checks++;
        if ({nb, tone_en, tone_id} !== {32'd0, 1'b1, 5'd12}) begin
          errors++;
          $display("FAIL rstmid_restart busy=%0d got=%b/%0d exp=0 1/12",
                   nb, tone_en, tone_id);
        end
      end
      rst = (i == 20);
      drive((i == 0 || i == 60) ? 3'b001 : 3'b000);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    rand_tick = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      checks++;
      if (obs !== m_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, m_vec());
      end
      en = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 15) == 0) drive(3'($urandom_range(1, 7)));
      else drive(3'b000);
    end
    en = 1'b1;
    rand_tick = 0;
  endtask

  initial begin
    int n2[8];
    n2 = '{21, 16, 14, 12, 9, 12, 14, 16};
    for (int r = 0; r < 3; r++) begin
      m_pend[r] = 0;
      for (int s = 0; s < 8; s++) begin
        p_note[r][s] = 31;
        p_dur[r][s] = 1;
      end
    end
    p_note[0][0] = 12; p_dur[0][0] = 10; p_len[0] = 1;
    p_note[1][0] = 0;  p_dur[1][0] = 20;
    p_note[1][1] = 31; p_dur[1][1] = 10;
    p_note[1][2] = 0;  p_dur[1][2] = 20; p_len[1] = 3;
    for (int s = 0; s < 8; s++) begin
      p_note[2][s] = n2[s];
      p_dur[2][s] = 25;
    end
    p_len[2] = 8;

    test_reset();
    test_place();
    test_illegal();
    test_both();
    test_preempt();
    test_en_drop();
    test_rst_mid();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
